// File: rtl/piso_serializer_tx_if.sv
// Load/serial bundle of the PISO transmitter. The producer and the serial sink
// use the master side, and the transmitter uses the slave side.
interface piso_serializer_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter. It sends one bit per clock and provides
// bit-valid and last-bit framing. It accepts the next word in the last-bit cycle.
module piso_serializer_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_serializer_tx_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic             load_ready_c;
    logic             busy_c;
    logic             accept;

    // The bit on the wire always lives at the outgoing end of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept = bus.load_valid && load_ready_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;
        if (accept) begin
            // Covers both a fresh start and a zero-bubble follow-on word.
            state_d     = SHIFT;
            shift_d     = bus.data_in;
            cnt_d       = '0;
            ser_out_d   = head_bit(bus.data_in);
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (ser_last_q) begin
                state_d     = IDLE;
                shift_d     = '0;
                cnt_d       = '0;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                ser_last_d  = 1'b0;
            end else begin
                shift_d     = advance(shift_q);
                cnt_d       = cnt_q + 1'b1;
                ser_out_d   = head_bit(advance(shift_q));
                ser_valid_d = 1'b1;
                ser_last_d  = ((cnt_q + 1'b1) == LAST_CNT);
            end
        end
    end

    always_comb begin
        load_ready_c = (state_q == IDLE) || ser_last_q;
        busy_c       = (state_q == SHIFT);
    end

    assign bus.load_ready = load_ready_c;
    assign bus.busy       = busy_c;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_last   = ser_last_q;
endmodule

// File: tb/tb_piso_serializer_tx.sv
// Scoreboard bench for piso_serializer_tx. It drives an MSB-first instance and
// an LSB-first instance, and uses expected bit streams that were written out by hand.
module tb_piso_serializer_tx;
    logic clk;
    logic rst;

    piso_serializer_tx_if #(.WIDTH(8)) b0 ();
    piso_serializer_tx_if #(.WIDTH(8)) b1 ();

    piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Each entry holds {expected ser_out, expected ser_last}.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int         run_len = 0;
    int         last_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic o, input logic l, input logic b);
        logic [1:0] e;
        int         depth;
        depth = (idx == 0) ? q0.size() : q1.size();
        if (v) begin
            tests_run++;
            if (depth == 0) begin
                tests_failed++;
                $display("FAIL unexpected_bit dut%0d: got ser_valid=1 expected no bit pending at %0t", idx, $time);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                tests_run--;
                check($sformatf("bit_dut%0d", idx), {30'd0, o, l}, {30'd0, e});
            end
        end else begin
            check($sformatf("idle_out_dut%0d", idx), {30'd0, o, l}, 32'd0);
        end
        check($sformatf("busy_dut%0d", idx), {31'd0, b}, {31'd0, v});
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, b0.ser_valid, b0.ser_out, b0.ser_last, b0.busy);
        mon(1, b1.ser_valid, b1.ser_out, b1.ser_last, b1.busy);
        if (b0.ser_valid) begin
            run_len = run_len + 1;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    // Called at a negedge. The stream is written in transmit order, with the
    // leftmost bit sent first.
    task automatic send(input int idx, input logic [7:0] word, input logic [7:0] stream);
        logic rdy;
        if (idx == 0) begin
            b0.data_in = word; b0.load_valid = 1'b1; rdy = b0.load_ready;
        end else begin
            b1.data_in = word; b1.load_valid = 1'b1; rdy = b1.load_ready;
        end
        check($sformatf("load_ready_on_send_dut%0d", idx), {31'd0, rdy}, 32'd1);
        for (int i = 7; i >= 0; i--) begin
            if (idx == 0) q0.push_back({stream[i], (i == 0)});
            else          q1.push_back({stream[i], (i == 0)});
        end
        @(negedge clk);
        b0.load_valid = 1'b0;
        b1.load_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((b0.ser_valid || b1.ser_valid || q0.size() != 0 || q1.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, (n >= 40)}, 32'd0);
    endtask

    task automatic wait_last0();
        int n;
        n = 0;
        while (!b0.ser_last && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ser_last_timeout", {31'd0, b0.ser_last}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        b0.data_in = '0; b0.load_valid = 1'b0;
        b1.data_in = '0; b1.load_valid = 1'b0;

        // Reset, then idle.
        @(negedge clk);
        b0.load_valid = 1'b1; b0.data_in = 8'hFF;
        @(negedge clk);
        b0.load_valid = 1'b0;
        check("reset_valid", {31'd0, b0.ser_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("post_reset_ready", {31'd0, b0.load_ready}, 32'd1);
        check("post_reset_outs", {28'd0, b0.ser_out, b0.ser_valid, b0.ser_last, b0.busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("idle_ready", {31'd0, b0.load_ready}, 32'd1);

        // Single word, MSB first.
        send(0, 8'hA5, 8'b1010_0101);
        wait_idle("single");
        check("single_run_len", last_run, 32'd8);

        // Back-to-back words, with the second offered in the ser_last cycle.
        send(0, 8'hA5, 8'b1010_0101);
        wait_last0();
        send(0, 8'h3C, 8'b0011_1100);
        wait_idle("b2b");
        check("b2b_run_len", last_run, 32'd16);

        // A load offered at the third bit is ignored.
        send(0, 8'hA5, 8'b1010_0101);
        @(negedge clk);
        @(negedge clk);
        b0.data_in = 8'hFF; b0.load_valid = 1'b1;
        check("ignored_load_ready", {31'd0, b0.load_ready}, 32'd0);
        @(negedge clk);
        b0.load_valid = 1'b0;
        wait_idle("ignored");
        check("ignored_run_len", last_run, 32'd8);

        // LSB first, on the second instance.
        send(1, 8'h01, 8'b1000_0000);
        wait_idle("lsb");
        send(1, 8'hC3, 8'b1100_0011);
        wait_idle("lsb2");

        // Reset in the middle of a word.
        send(0, 8'hA5, 8'b1010_0101);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_outs", {29'd0, b0.ser_valid, b0.ser_last, b0.busy}, 32'd0);
        check("midreset_ready", {31'd0, b0.load_ready}, 32'd1);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(0, 8'hC3, 8'b1100_0011);
        wait_idle("after_reset");
        check("after_reset_run_len", last_run, 32'd8);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
